// File: rtl/if_prefetch_stage.sv
// if_prefetch_stage: IF stage with prefetch queue, credit-based multi-outstanding fetch and counted stale discard.
// Optional perf counters are enabled by defining IF_PREFETCH_PERF_EN.
`ifndef NO_EX
`define NO_EX 5'h1f
`endif
`ifndef ADEL
`define ADEL 5'h04
`endif
module if_prefetch_stage #(
   parameter int DEPTH = 4,
   parameter int MAX_OUTSTANDING = 2,
   parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        ds_allowin,
   output logic        fs_to_ds_valid,
   output logic [31:0] fs_to_ds_pc,
   output logic [31:0] fs_to_ds_inst,
   output logic [4:0]  fs_to_ds_excode,
   output logic        inst_sram_req,
   output logic        inst_sram_wr,
   output logic [1:0]  inst_sram_size,
   output logic [3:0]  inst_sram_wstrb,
   output logic [31:0] inst_sram_addr,
   output logic [31:0] inst_sram_wdata,
   input  logic        inst_sram_addr_ok,
   input  logic        inst_sram_data_ok,
   input  logic [31:0] inst_sram_rdata
`ifdef IF_PREFETCH_PERF_EN
   ,
   output logic [31:0] perf_discard_cnt,
   output logic [31:0] perf_bubble_cnt
`endif
);
   localparam int QW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = $clog2(MAX_OUTSTANDING + 1);
   localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;

   logic [31:0]   fpc, hold_addr;
   logic          hold, stale_req, halt, run;
   logic [IW-1:0] inflight, discard;
   logic [31:0]   q_pc [DEPTH];
   logic [31:0]   q_inst [DEPTH];
   logic [4:0]    q_ex [DEPTH];
   logic [QW-1:0] q_rd, q_wr;
   logic [CW-1:0] qcount;
   logic [31:0]   pend [MAX_OUTSTANDING];
   logic [PW-1:0] p_rd, p_wr;

   logic [31:0] used, push_pc, push_inst;
   logic [4:0]  push_ex;
   logic        misal, credit, accept, ret, drop, adel_push, q_push, q_pop;

   function automatic logic [PW-1:0] pinc(input logic [PW-1:0] p);
      return p == PW'(MAX_OUTSTANDING - 1) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      misal = fpc[1:0] != 2'b00;
      used = 32'(qcount) + 32'(inflight) - 32'(discard);
      credit = 32'(inflight) < MAX_OUTSTANDING && used < DEPTH;
      inst_sram_req = hold | (run & ~halt & ~misal & credit);
      inst_sram_addr = hold ? hold_addr : fpc;
      accept = inst_sram_req & inst_sram_addr_ok;
      ret = inst_sram_data_ok;
      drop = ret & (discard != '0);
      adel_push = run & misal & ~halt & ~hold & (32'(qcount) < DEPTH) & (inflight == discard);
      q_push = (ret & ~drop) | adel_push;
      q_pop = fs_to_ds_valid & ds_allowin;
      push_pc = adel_push ? fpc : pend[p_rd];
      push_inst = adel_push ? 32'h0 : inst_sram_rdata;
      push_ex = adel_push ? `ADEL : `NO_EX;
   end

   assign fs_to_ds_valid  = qcount != '0;
   assign fs_to_ds_pc     = q_pc[q_rd];
   assign fs_to_ds_inst   = q_inst[q_rd];
   assign fs_to_ds_excode = q_ex[q_rd];
   assign inst_sram_wr    = 1'b0;
   assign inst_sram_size  = 2'b10;
   assign inst_sram_wstrb = 4'h0;
   assign inst_sram_wdata = 32'h0;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         fpc <= RESET_PC;
         hold_addr <= RESET_PC;
         hold <= 1'b0;
         stale_req <= 1'b0;
         halt <= 1'b0;
         run <= 1'b0;
         inflight <= '0;
         discard <= '0;
         q_rd <= '0;
         q_wr <= '0;
         qcount <= '0;
         p_rd <= '0;
         p_wr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            q_pc[i] <= 32'h0;
            q_inst[i] <= 32'h0;
            q_ex[i] <= `NO_EX;
         end
         for (int i = 0; i < MAX_OUTSTANDING; i++) pend[i] <= 32'h0;
      end else begin
         run <= 1'b1;
         if (accept) begin
            pend[p_wr] <= inst_sram_addr;
            p_wr <= pinc(p_wr);
         end
         if (ret) p_rd <= pinc(p_rd);
         inflight <= inflight + IW'(accept) - IW'(ret);
         hold <= inst_sram_req & ~inst_sram_addr_ok;
         hold_addr <= inst_sram_addr;
         if (redirect_valid) begin
            // every response still owed, including one accepted now, belongs to the old stream
            fpc <= redirect_pc;
            halt <= 1'b0;
            stale_req <= inst_sram_req & ~inst_sram_addr_ok;
            discard <= inflight + IW'(accept) - IW'(ret);
            qcount <= '0;
            q_rd <= '0;
            q_wr <= '0;
         end else begin
            if (accept & ~stale_req) fpc <= fpc + 32'd4;
            if (accept) stale_req <= 1'b0;
            if (adel_push) halt <= 1'b1;
            discard <= discard + IW'(accept & stale_req) - IW'(drop);
            if (q_push) begin
               q_pc[q_wr] <= push_pc;
               q_inst[q_wr] <= push_inst;
               q_ex[q_wr] <= push_ex;
               q_wr <= q_wr + 1'b1;
            end
            if (q_pop) q_rd <= q_rd + 1'b1;
            qcount <= qcount + CW'(q_push) - CW'(q_pop);
         end
      end
   end

`ifdef IF_PREFETCH_PERF_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         perf_discard_cnt <= 32'h0;
         perf_bubble_cnt <= 32'h0;
      end else begin
         if (ret & (redirect_valid | (discard != '0))) perf_discard_cnt <= perf_discard_cnt + 32'd1;
         if (ds_allowin & ~fs_to_ds_valid) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      end
   end
`endif

   a_queue_overflow: assert property (@(posedge clk) disable iff (!resetn)
      !(q_push && !q_pop && !redirect_valid && 32'(qcount) == DEPTH));
   a_pend_overflow: assert property (@(posedge clk) disable iff (!resetn)
      !(accept && !ret && 32'(inflight) == MAX_OUTSTANDING));
endmodule

// File: doc/if_prefetch_stage.md
# if_prefetch_stage

Parametrised instruction-fetch stage with a multi-entry prefetch queue and several outstanding requests on the SRAM-like instruction interface (req/addr_ok/data_ok). It sits between the inst-SRAM bridge and the ID stage. It replaces one-request-at-a-time fetch with credit-based issue, a single unified redirect port for exception, ERET and branch, and counted discard of stale responses.

## Interface
Parameters:
- `DEPTH`, 4: prefetch queue entries, power of 2, ≥2.
- `MAX_OUTSTANDING`, 2: maximum requests accepted (addr_ok) whose data_ok has not yet returned, 1..DEPTH.
- `RESET_PC`, 32'hbfc00000: first fetch address after reset.

Ports:
- `clk` in 1: single clock.
- `resetn` in 1: asynchronous, active-low reset.
- `redirect_valid` in 1: flush and restart fetch, for exception, ERET or taken branch; priority is resolved upstream.
- `redirect_pc` in 32: new fetch PC.
- `ds_allowin` in 1: ID stage accepts the head entry.
- `fs_to_ds_valid` out 1: head entry valid.
- `fs_to_ds_pc` out 32: PC of the head entry.
- `fs_to_ds_inst` out 32: instruction word; 0 when excode is ADEL.
- `fs_to_ds_excode` out 5: `NO_EX or `ADEL (from mycpu.h).
- `inst_sram_req` out 1: request valid.
- `inst_sram_wr` out 1: constant 0.
- `inst_sram_size` out 2: constant 2'b10.
- `inst_sram_wstrb` out 4: constant 0.
- `inst_sram_addr` out 32: request address, word aligned.
- `inst_sram_wdata` out 32: constant 0.
- `inst_sram_addr_ok` in 1: request accepted this cycle.
- `inst_sram_data_ok` in 1: response valid this cycle; responses return in order.
- `inst_sram_rdata` in 32: response data.

## Operation
- State:
  - fetch PC `fpc`.
  - Queue of {pc, inst, excode}.
  - `pend_pc` FIFO of MAX_OUTSTANDING PCs.
  - `inflight` count, width clog2(MAX_OUTSTANDING+1).
  - `discard` count, always ≤ inflight.
  - `stale_req` flag.
  - `halt` flag.
- Issue rule:
  - Assert req when !halt && inflight < MAX_OUTSTANDING && (qcount + inflight − discard) < DEPTH.
  - addr = fpc.
  - On req && addr_ok: push fpc into pend_pc, inflight++, fpc += 4 (modulo 2^32).
- Protocol rule: once req is high, req and addr are held stable until addr_ok, including across a redirect. The held request is marked stale_req; when it is accepted, it increments discard. The new PC is issued on the following request.
- Response handling: on data_ok, pop pend_pc and decrement inflight.
  - If discard > 0: drop the data and decrement discard.
  - Otherwise: push {pc, rdata, NO_EX} into the queue.
- Dequeue: on fs_to_ds_valid && ds_allowin, pop the head.
- Redirect, in the same cycle as `redirect_valid`:
  - Queue cleared.
  - `discard <= inflight + accept − ret`, where accept = this cycle's req&&addr_ok and ret = this cycle's data_ok (that returning word is dropped).
  - fpc ← redirect_pc; halt ← 0.
  - Redirect overrides any push or pop in the same cycle.
- Misaligned PC (fpc[1:0] ≠ 0):
  - No request is issued.
  - When the queue has a free slot and inflight == discard, push {fpc, 0, ADEL} once, then set halt.
  - Only a redirect clears halt.
- Overflow: the credit rule guarantees a push never hits a full queue. An overflow is a design error and must be caught by an assertion.

## Timing
- Reset (async, resetn = 0):
  - fs_to_ds_valid = 0, inst_sram_req = 0, inst_sram_addr = RESET_PC.
  - fs_to_ds_pc/inst = 0, excode = NO_EX.
  - Counters 0, flags 0, fpc = RESET_PC.
- req first asserts in the first cycle after resetn deasserts.
- Request is accepted in the same cycle addr_ok is high.
- data_ok earliest arrives the cycle after acceptance.
- The queue is registered: the head becomes visible the cycle after its data_ok, so best-case data_ok→fs_to_ds_valid latency is 1 cycle.
- Back-to-back throughput is one instruction per cycle when addr_ok and data_ok are continuously high.
- Redirect: the first new-PC request is presented the cycle after redirect_valid, or the cycle after the stale request is accepted. fs_to_ds_valid = 0 the cycle after redirect.
- Empty queue with data_ok in the same cycle as a pop: the pop applies to the old head and the push lands behind it.
- Reset asserted mid-transaction clears all state. The bridge must be reset in the same domain.

## Configuration
- `IF_PREFETCH_PERF_EN` defined:
  - Adds outputs `perf_discard_cnt` (32) and `perf_bubble_cnt` (32), both reset to 0 and wrapping at 2^32.
  - `perf_discard_cnt` increments once per dropped data_ok.
  - `perf_bubble_cnt` increments once per cycle in which ds_allowin is high and fs_to_ds_valid is low.
- Undefined: the ports and counters are absent. Functional behaviour is identical.

## Test plan
- Reset release, always-ready memory (addr_ok = 1, data_ok one cycle later) → addresses bfc00000, bfc00004, … on consecutive cycles; ID receives one instruction per cycle in PC order.
- ds_allowin = 0 held, DEPTH = 4, MAX_OUTSTANDING = 2 → exactly 4 requests accepted, then req stays low; releasing ds_allowin resumes fetch with no lost or duplicated PC.
- Redirect to bfc00380 with inflight = 2 and one data_ok in the redirect cycle → 2 responses dropped in total (the in-cycle one plus one later); the next delivered PC is bfc00380.
- Redirect while req is held without addr_ok for 3 cycles → addr stays at the old PC until accepted; that response is discarded; the next request uses redirect_pc.
- Redirect to bfc00382 → no request issued; ID receives {pc = bfc00382, inst = 0, excode = ADEL}; req stays low until a redirect to bfc00380.
- With `IF_PREFETCH_PERF_EN` defined, the third scenario → perf_discard_cnt = 2.
